// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the cache-side AXI read arbiter: requester indices,
// burst encoding and arbiter FSM states.
package axi_rd_arbiter_pkg;

    localparam int unsigned RD_REQ_ICACHE  = 0;
    localparam int unsigned RD_REQ_DCACHE  = 1;
    localparam int unsigned RD_REQ_UNCACHE = 2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from the index after the last grant, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int unsigned w_cand;
        found  = 1'b0;
        idx    = '0;
        w_cand = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_cand = (32'(last) + off) % NUM_REQ;
            if (!found && req[IDX_W'(w_cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel among the ICache, DCache and
// uncached load port; one transaction in flight at a time.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter logic [3:0]  AXI_ID  = 4'd0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      m_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0] m_araddr,
    input  logic [NUM_REQ*8-1:0]    m_arlen,
    input  logic [NUM_REQ*3-1:0]    m_arsize,
    output logic [NUM_REQ-1:0]      m_arready,
    output logic [NUM_REQ-1:0]      m_rvalid,
    output logic [NUM_REQ-1:0]      m_rlast,
    output logic [DATA_W-1:0]       m_rdata,
    input  logic [NUM_REQ-1:0]      m_rready,
    output logic [3:0]              s_arid,
    output logic [ADDR_W-1:0]       s_araddr,
    output logic [7:0]              s_arlen,
    output logic [2:0]              s_arsize,
    output logic [1:0]              s_arburst,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    input  logic [DATA_W-1:0]       s_rdata,
    input  logic                    s_rlast,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    output logic                    busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     r_last_grant;
    logic [ADDR_W-1:0]    r_araddr;
    logic [7:0]           r_arlen;
    logic [2:0]           r_arsize;
    logic                 w_pick_found;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [ADDR_W-1:0]    w_addr_arr [NUM_REQ];
    logic [7:0]           w_len_arr  [NUM_REQ];
    logic [2:0]           w_size_arr [NUM_REQ];

    // Unpack the flat per-requester request fields.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g] = m_araddr[g*ADDR_W +: ADDR_W];
        assign w_len_arr[g]  = m_arlen[g*8 +: 8];
        assign w_size_arr[g] = m_arsize[g*3 +: 3];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (m_arvalid),
        .last  (r_last_grant),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    assign s_arid  = AXI_ID;
    assign m_rdata = s_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant and request fields are captured only while idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
        end else begin
            if (r_state == ARB_IDLE && w_pick_found) begin
                r_grant_idx <= w_pick_idx;
                r_araddr    <= w_addr_arr[w_pick_idx];
                r_arlen     <= w_len_arr[w_pick_idx];
                r_arsize    <= w_size_arr[w_pick_idx];
            end
            if (r_state == ARB_ADDR && s_arready) begin
                r_last_grant <= r_grant_idx;
            end
        end
    end

    // Next state and channel steering; everything is held low while in reset.
    always_comb begin
        w_state_nxt = r_state;
        s_arvalid   = 1'b0;
        s_arburst   = 2'b00;
        s_araddr    = '0;
        s_arlen     = '0;
        s_arsize    = '0;
        s_rready    = 1'b0;
        m_arready   = '0;
        m_rvalid    = '0;
        m_rlast     = '0;
        busy        = 1'b0;
        if (resetn) begin
            busy     = (r_state != ARB_IDLE);
            s_araddr = r_araddr;
            s_arlen  = r_arlen;
            s_arsize = r_arsize;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_found) begin
                        w_state_nxt = ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    s_arvalid              = 1'b1;
                    s_arburst              = AXI_BURST_INCR;
                    m_arready[r_grant_idx] = s_arready;
                    if (s_arready) begin
                        w_state_nxt = ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    s_rready              = m_rready[r_grant_idx];
                    m_rvalid[r_grant_idx] = s_rvalid;
                    m_rlast[r_grant_idx]  = s_rlast;
                    if (s_rvalid && m_rready[r_grant_idx] && s_rlast) begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ARB_IDLE;
                end
            endcase
        end
    end

endmodule
